lsu_data_mem: RTL and testbench
===============================

# lsu_data_mem

Byte-addressable, little-endian data memory with a valid/ready request port and a fixed-latency response port, for the load/store stage of the single-cycle core and its multi-cycle successors. Supports byte, halfword and word accesses with sign or zero extension on loads. Flags misaligned or illegal-size accesses as errors and suppresses them. Read latency is parametrised so the block can stand in for a synchronous SRAM macro.

## Interface
- XLEN, 32: data width in bits; fixed at 32 for this generation.
- ADDR_W, 12: byte-address width; memory holds 2**ADDR_W bytes.
- RD_LATENCY, 2: cycles from load acceptance to load response; legal range 1–4.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  XLEN  store data; low-order bytes used for sub-word stores.
- rsp_valid  out  1  one-cycle pulse; response present.
- rsp_rdata  out  XLEN  load result; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned or illegal size.

## Operation
- Handshake: request accepted on a rising edge where req_valid && req_ready. Only one request is outstanding at a time. There is no response back-pressure; the consumer must take rsp_* on the pulse.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0. Counter runs down RD_LATENCY-1 cycles.
  - RESP: rsp_valid=1, req_ready=1.
- FSM transitions:
  - Accepted store, or any errored request → RESP.
  - Accepted good load: RD_LATENCY=1 → RESP; otherwise → WAIT, with the counter loaded to RD_LATENCY-2.
  - WAIT with counter 0 → RESP.
  - RESP: on a new acceptance, follow the IDLE rules; otherwise → IDLE.
- Alignment rules:
  - Halfword needs addr[0]=0.
  - Word needs addr[1:0]=00.
  - Size 11 is always an error.
  - An error request writes nothing, returns rdata=0 and err=1, and takes the store path timing.
- Stores: bytes written at the acceptance edge, little-endian.
  - Byte: mem[a]=wdata[7:0].
  - Halfword: additionally mem[a+1]=wdata[15:8].
  - Word: additionally mem[a+2]=wdata[23:16] and mem[a+3]=wdata[31:24].
  - Response: rdata=0, err=0.
- Loads:
  - Bytes are read and the address/size/unsigned fields are captured at acceptance.
  - Result is assembled as {mem[a+3],mem[a+2],mem[a+1],mem[a]}, truncated to size.
  - Byte/halfword results are extended to 32 bits: zero-extended if req_unsigned=1, else sign-extended from bit 7 or bit 15.
  - Word ignores req_unsigned.
- Address arithmetic is within ADDR_W bits only. Because alignment is enforced, no access wraps past the top byte.
- Memory contents are not cleared by rst; the bench initialises memory with stores.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Store/error latency: accepted at edge T → rsp_valid high in the cycle after T, i.e. 1 cycle.
- Load latency: accepted at edge T → rsp_valid high in the cycle starting at edge T+RD_LATENCY-1. With RD_LATENCY=1, loads issue back-to-back at one per cycle.
- Stores are fully pipelined: one per cycle. After a load with RD_LATENCY>1, req_ready stays low for RD_LATENCY-1 cycles.
- Read-after-write: a load accepted at any edge after a store's acceptance edge returns the stored data.
- rst asserted mid-operation:
  - Pending load is dropped; no rsp_valid is produced.
  - Outputs take reset values at the next edge.
  - A store committed at an earlier edge persists.
- rst and req_valid in the same cycle: request ignored; nothing written.
- rsp_rdata and rsp_err are registered and hold their values only while rsp_valid=1; they are 0 otherwise.

## Test plan
- Word store/load: store 0xDEADBEEF at 0x010, then load word at 0x010 → rdata=0xDEADBEEF, err=0, rsp_valid exactly RD_LATENCY cycles after acceptance.
- Extension: store byte 0x80 at 0x021, then load signed byte → 0xFFFFFF80 and unsigned byte → 0x00000080. Store half 0x8001 at 0x022, then load signed half → 0xFFFF8001.
- Misalignment: word store 0x11223344 at 0x013 → err=1, rdata=0. A following load word at 0x010 returns the prior contents unchanged. Size 11 at 0x000 → err=1.
- Handshake: with RD_LATENCY=3, hold req_valid high with 3 loads → req_ready low for 2 cycles after each acceptance, 3 response pulses, no lost or duplicated requests. With RD_LATENCY=1 → one response per cycle.
- Reset mid-load: RD_LATENCY=4; accept a load, assert rst in the next cycle → no rsp_valid, req_ready=1 after reset. A store done before the reset is still readable.
- Little-endian layout: word store 0x0A0B0C0D at 0x100, then byte loads at 0x100..0x103 (unsigned) → 0x0D, 0x0C, 0x0B, 0x0A.

Source files
------------

// File: rtl/lsu_data_mem.sv
`timescale 1ns/1ps
// lsu_data_mem: byte-addressable little-endian data memory with a valid/ready
// request port and a fixed-latency response port (sized, sign/zero-extended loads).
module lsu_data_mem #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] CNT_LOAD = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0]        mem [DEPTH];
    logic              accept;
    logic              misaligned;
    logic              req_err;
    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   load_data;

    assign req_ready = (state_q != WAIT);
    assign accept    = req_valid && req_ready && !rst;

    assign addr1 = req_addr + ADDR_W'(1);
    assign addr2 = req_addr + ADDR_W'(2);
    assign addr3 = req_addr + ADDR_W'(3);

    always_comb begin
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign req_err = (req_size == 2'b11) || misaligned;

    // Sub-word loads at the top byte wrap the unused upper lanes; they are masked below.
    assign raw = {mem[addr3], mem[addr2], mem[addr1], mem[req_addr]};

    always_comb begin
        load_data = raw;
        case (req_size)
            2'b00:   load_data = {{(XLEN-8){~req_unsigned & raw[7]}}, raw[7:0]};
            2'b01:   load_data = {{(XLEN-16){~req_unsigned & raw[15]}}, raw[15:0]};
            default: load_data = raw;
        endcase
    end

    // NOTE: the storage array has no reset; rst only clears control and response state.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            mem[req_addr] <= req_wdata[7:0];
            if (req_size != 2'b00) begin
                mem[addr1] <= req_wdata[15:8];
            end
            if (req_size == 2'b10) begin
                mem[addr2] <= req_wdata[23:16];
                mem[addr3] <= req_wdata[31:24];
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        rdata_d = '0;
        err_d   = 1'b0;

        case (state_q)
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    rdata_d = pend_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance only happens from IDLE or RESP, so it overrides the defaults above.
        if (accept) begin
            if (req_err || req_we) begin
                state_d = RESP;
                err_d   = req_err;
                rdata_d = '0;
            end else if (RD_LATENCY == 1) begin
                state_d = RESP;
                rdata_d = load_data;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
                pend_d  = load_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            pend_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
`timescale 1ns/1ps
// tb_lsu_data_mem: three instances (RD_LATENCY 3, 1, 4) driven with directed and
// random request streams, checked cycle by cycle against a byte-array reference model.
module tb_lsu_data_mem;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } got_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_we;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    logic        vld    [3];
    logic        rdy    [3];
    logic        rsp_v  [3];
    logic [31:0] rsp_rd [3];
    logic        rsp_e  [3];

    logic [7:0]  mm [3][4096];
    req_t        pend_q[$];
    got_t        got_q[$];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lsu_data_mem #(
            .XLEN(32), .ADDR_W(12), .RD_LATENCY(lat_of(g))
        ) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(vld[g]), .req_ready(rdy[g]),
            .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
            .req_unsigned(req_unsigned), .req_wdata(req_wdata),
            .rsp_valid(rsp_v[g]), .rsp_rdata(rsp_rd[g]), .rsp_err(rsp_e[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic req_t mk(input logic we, input logic [11:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.size = size; r.uns = uns; r.wdata = wdata;
        return r;
    endfunction

    task automatic drive(input req_t r);
        req_we = r.we; req_addr = r.addr; req_size = r.size;
        req_unsigned = r.uns; req_wdata = r.wdata;
    endtask

    // Reference behaviour: applies a store to the model, or returns the load/error result.
    function automatic void model(input int d, input req_t r, output logic [31:0] rd,
                                  output logic er, output int lat);
        int     n;
        longint v;
        er  = (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) ||
              (r.size == 2'd2 && r.addr[1:0] != 2'd0);
        n   = 1 << r.size;
        rd  = '0;
        lat = 1;
        if (er) return;
        if (r.we) begin
            for (int i = 0; i < n; i++) mm[d][12'(int'(r.addr) + i)] = 8'(r.wdata >> (8 * i));
            return;
        end
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mm[d][12'(int'(r.addr) + i)]) << (8 * i));
        if (n < 4 && !r.uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rd  = 32'(v);
        lat = lat_of(d);
    endfunction

    // Issues every request in pend_q with req_valid held high, checking each cycle.
    task automatic run(input int d);
        exp_t        eq[$];
        int          c = 0;
        int          next_acc = 1;
        int          issued = 0;
        int          n = pend_q.size();
        logic [31:0] rd;
        logic        er;
        int          lat;
        got_q.delete();
        @(negedge clk);
        while (c < 4000) begin
            if (eq.size() > 0 && eq[0].due == c) begin
                check($sformatf("rsp_valid d%0d c%0d", d, c), 32'(rsp_v[d]), 32'd1);
                check($sformatf("rsp_rdata d%0d c%0d", d, c), rsp_rd[d], eq[0].rd);
                check($sformatf("rsp_err d%0d c%0d", d, c), 32'(rsp_e[d]), 32'(eq[0].err));
                got_q.push_back('{rsp_rd[d], rsp_e[d]});
                void'(eq.pop_front());
            end else begin
                check($sformatf("rsp_idle d%0d c%0d", d, c),
                      {rsp_rd[d][30:0], rsp_v[d]} | 32'(rsp_e[d]) | {31'd0, rsp_rd[d][31]}, 32'd0);
            end
            check($sformatf("req_ready d%0d c%0d", d, c), 32'(rdy[d]), 32'(c + 1 >= next_acc));
            if (issued == n && eq.size() == 0) break;
            if (issued < n) begin
                drive(pend_q[issued]);
                vld[d] = 1'b1;
                if (c + 1 >= next_acc) begin
                    model(d, pend_q[issued], rd, er, lat);
                    eq.push_back('{c + lat, rd, er});
                    next_acc = c + 1 + lat;
                    issued++;
                end
            end else begin
                vld[d] = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        vld[d] = 1'b0;
        check($sformatf("drained d%0d", d), 32'(eq.size()), 32'd0);
        check($sformatf("issued d%0d", d), 32'(issued), 32'(n));
        pend_q.delete();
    endtask

    task automatic directed(input int d);
        pend_q.push_back(mk(1, 12'h010, 2, 0, 32'hDEADBEEF));
        pend_q.push_back(mk(0, 12'h010, 2, 0, 32'h0));
        pend_q.push_back(mk(1, 12'h021, 0, 0, 32'h00000080));
        pend_q.push_back(mk(0, 12'h021, 0, 0, 32'h0));
        pend_q.push_back(mk(0, 12'h021, 0, 1, 32'h0));
        pend_q.push_back(mk(1, 12'h022, 1, 0, 32'h00008001));
        pend_q.push_back(mk(0, 12'h022, 1, 0, 32'h0));
        pend_q.push_back(mk(1, 12'h013, 2, 0, 32'h11223344));
        pend_q.push_back(mk(0, 12'h010, 2, 0, 32'h0));
        pend_q.push_back(mk(0, 12'h000, 3, 0, 32'h0));
        pend_q.push_back(mk(1, 12'h100, 2, 0, 32'h0A0B0C0D));
        for (int i = 0; i < 4; i++) pend_q.push_back(mk(0, 12'(12'h100 + i), 0, 1, 32'h0));
        run(d);
        check($sformatf("dir_count d%0d", d), 32'(got_q.size()), 32'd15);
        if (got_q.size() == 15) begin
            check($sformatf("word_ld d%0d", d), got_q[1].rd, 32'hDEADBEEF);
            check($sformatf("word_ld_err d%0d", d), 32'(got_q[1].err), 32'd0);
            check($sformatf("sbyte_ld d%0d", d), got_q[3].rd, 32'hFFFFFF80);
            check($sformatf("ubyte_ld d%0d", d), got_q[4].rd, 32'h00000080);
            check($sformatf("shalf_ld d%0d", d), got_q[6].rd, 32'hFFFF8001);
            check($sformatf("misal_err d%0d", d), 32'(got_q[7].err), 32'd1);
            check($sformatf("misal_rd d%0d", d), got_q[7].rd, 32'd0);
            check($sformatf("misal_keep d%0d", d), got_q[8].rd, 32'hDEADBEEF);
            check($sformatf("size3_err d%0d", d), 32'(got_q[9].err), 32'd1);
            check($sformatf("le_b0 d%0d", d), got_q[11].rd, 32'h0D);
            check($sformatf("le_b1 d%0d", d), got_q[12].rd, 32'h0C);
            check($sformatf("le_b2 d%0d", d), got_q[13].rd, 32'h0B);
            check($sformatf("le_b3 d%0d", d), got_q[14].rd, 32'h0A);
        end
    endtask

    initial begin
        req_t r;
        rst = 1'b1;
        drive(mk(0, 12'h0, 0, 0, 32'h0));
        for (int d = 0; d < 3; d++) vld[d] = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid d%0d", d), 32'(rsp_v[d]), 32'd0);
            check($sformatf("rst_ready d%0d", d), 32'(rdy[d]), 32'd1);
            check($sformatf("rst_rdata d%0d", d), rsp_rd[d], 32'd0);
            check($sformatf("rst_err d%0d", d), 32'(rsp_e[d]), 32'd0);
        end
        rst = 1'b0;

        // Give every instance a fully known window 0x000..0x1FF.
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 512; a += 4) pend_q.push_back(mk(1, 12'(a), 2, 0, $urandom));
            run(d);
        end

        for (int d = 0; d < 3; d++) directed(d);

        // Reset in the cycle after a load is accepted (RD_LATENCY=4 instance).
        drive(mk(0, 12'h010, 2, 0, 32'h0));
        vld[2] = 1'b1;
        check("rstld_ready_pre", 32'(rdy[2]), 32'd1);
        @(negedge clk);
        vld[2] = 1'b0;
        rst = 1'b1;
        check("rstld_wait_ready", 32'(rdy[2]), 32'd0);
        check("rstld_wait_valid", 32'(rsp_v[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rstld_valid", 32'(rsp_v[2]), 32'd0);
        check("rstld_ready", 32'(rdy[2]), 32'd1);
        check("rstld_rdata", rsp_rd[2], 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rstld_quiet %0d", i), 32'(rsp_v[2]), 32'd0);
        end
        pend_q.push_back(mk(0, 12'h010, 2, 0, 32'h0));
        run(2);
        check("rstld_persist", (got_q.size() > 0) ? got_q[0].rd : 32'hX, 32'hDEADBEEF);

        // A store presented while rst is high must be ignored.
        rst = 1'b1;
        drive(mk(1, 12'h1F0, 2, 0, 32'hFFFFFFFF));
        vld[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vld[0] = 1'b0;
        check("rstst_valid", 32'(rsp_v[0]), 32'd0);
        pend_q.push_back(mk(0, 12'h1F0, 2, 0, 32'h0));
        run(0);

        // Random mixed traffic, mostly aligned, including illegal sizes.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 300; i++) begin
                r.we    = 1'($urandom % 2);
                r.size  = 2'($urandom % 4);
                r.addr  = 12'($urandom % 512);
                r.uns   = 1'($urandom % 2);
                r.wdata = $urandom;
                if ($urandom % 4 != 0 && r.size != 2'd3)
                    r.addr = r.addr & ~12'((1 << r.size) - 1);
                pend_q.push_back(r);
            end
            run(d);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
